// File: rtl/execute_stage.sv
// RV32IM execute stage: operand forwarding, ALU, branch resolution, EX/MEM register.
// Optional iterative multiply/divide unit is built only when MULDIV_EN is defined.

package decode_pkg;
  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [1:0]  ALUOp;
    logic        ALUSrc;
    logic        Branch;
    logic        Jump;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        MemToReg;
    logic        muldiv;
  } id_ex_t;
endpackage

package execute_pkg;
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] pc_plus4;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        MemToReg;
  } ex_mem_t;
endpackage

module execute_stage #(
  parameter int unsigned MULDIV_ITERS = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  decode_pkg::id_ex_t   id_ex,
  input  logic [4:0]           exmem_fwd_rd,
  input  logic                 exmem_fwd_we,
  input  logic [31:0]          exmem_fwd_data,
  input  logic [4:0]           wb_addr,
  input  logic                 wb_we,
  input  logic [31:0]          wb_data,
  output execute_pkg::ex_mem_t ex_mem,
  output logic                 branch_taken,
  output logic [31:0]          branch_target,
  output logic                 ex_busy
);
  import execute_pkg::*;

  if (MULDIV_ITERS != 32) begin : g_bad_iters
    $error("execute_stage: MULDIV_ITERS must be 32");
  end

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic        br_cond;
  ex_mem_t     ex_word;

  // Forwarding: the youngest producer (EX/MEM) wins over MEM/WB; x0 never forwards.
  always_comb begin
    fwd_a = id_ex.rs1_data;
    if (exmem_fwd_we && (exmem_fwd_rd == id_ex.rs1) && (id_ex.rs1 != 5'd0))
      fwd_a = exmem_fwd_data;
    else if (wb_we && (wb_addr == id_ex.rs1) && (id_ex.rs1 != 5'd0))
      fwd_a = wb_data;

    fwd_b = id_ex.rs2_data;
    if (exmem_fwd_we && (exmem_fwd_rd == id_ex.rs2) && (id_ex.rs2 != 5'd0))
      fwd_b = exmem_fwd_data;
    else if (wb_we && (wb_addr == id_ex.rs2) && (id_ex.rs2 != 5'd0))
      fwd_b = wb_data;
  end

  assign alu_b = id_ex.ALUSrc ? id_ex.imm : fwd_b;

  always_comb begin
    alu_res = 32'd0;
    case (id_ex.ALUOp)
      2'b00: alu_res = fwd_a + alu_b;
      2'b01: alu_res = fwd_a - alu_b;
      2'b10: begin
        case (id_ex.funct3)
          3'b000: alu_res = id_ex.funct7_5 ? (fwd_a - alu_b) : (fwd_a + alu_b);
          3'b001: alu_res = fwd_a << alu_b[4:0];
          3'b010: alu_res = {31'd0, ($signed(fwd_a) < $signed(alu_b))};
          3'b011: alu_res = {31'd0, (fwd_a < alu_b)};
          3'b100: alu_res = fwd_a ^ alu_b;
          3'b101: alu_res = id_ex.funct7_5 ? 32'($signed(fwd_a) >>> alu_b[4:0])
                                           : (fwd_a >> alu_b[4:0]);
          3'b110: alu_res = fwd_a | alu_b;
          3'b111: alu_res = fwd_a & alu_b;
          default: alu_res = 32'd0;
        endcase
      end
      default: alu_res = id_ex.imm;
    endcase
  end

  // Branch compare always uses the forwarded register operands, never the immediate.
  always_comb begin
    br_cond = 1'b0;
    case (id_ex.funct3)
      3'b000: br_cond = (fwd_a == fwd_b);
      3'b001: br_cond = (fwd_a != fwd_b);
      3'b100: br_cond = ($signed(fwd_a) <  $signed(fwd_b));
      3'b101: br_cond = ($signed(fwd_a) >= $signed(fwd_b));
      3'b110: br_cond = (fwd_a <  fwd_b);
      3'b111: br_cond = (fwd_a >= fwd_b);
      default: br_cond = 1'b0;
    endcase
  end

  assign branch_taken  = ((id_ex.Branch && br_cond) || id_ex.Jump) && !ex_busy;
  assign branch_target = (id_ex.pc_plus4 - 32'd4) + id_ex.imm;

  always_comb begin
    ex_word            = '0;
    ex_word.alu_result = alu_res;
    ex_word.rs2_data   = fwd_b;
    ex_word.rd         = id_ex.rd;
    ex_word.funct3     = id_ex.funct3;
    ex_word.pc_plus4   = id_ex.pc_plus4;
    ex_word.RegWrite   = id_ex.RegWrite;
    ex_word.MemRead    = id_ex.MemRead;
    ex_word.MemWrite   = id_ex.MemWrite;
    ex_word.MemToReg   = id_ex.MemToReg;
  end

`ifdef MULDIV_EN
  localparam int unsigned CNT_W = $clog2(MULDIV_ITERS + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_t;

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      acc;
  logic [31:0]      opnd;
  logic [31:0]      dividend;
  logic [2:0]       md_f3;
  logic             md_neg;
  logic             rem_neg;
  logic             div_zero;
  ex_mem_t          md_hold;
  ex_mem_t          md_done_word;

  logic        st_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] div_next;
  logic [63:0] prod;
  logic [31:0] quo, rem;
  logic [31:0] md_result;

  // Operands are reduced to magnitudes; the sign is reapplied once the loop finishes.
  always_comb begin
    st_div = id_ex.funct3[2];
    a_sgn  = st_div ? !id_ex.funct3[0] : (id_ex.funct3[1:0] != 2'b11);
    b_sgn  = st_div ? !id_ex.funct3[0] : !id_ex.funct3[1];
    a_neg  = a_sgn && fwd_a[31];
    b_neg  = b_sgn && fwd_b[31];
    a_mag  = a_neg ? (32'd0 - fwd_a) : fwd_a;
    b_mag  = b_neg ? (32'd0 - fwd_b) : fwd_b;
  end

  // acc = {partial product, multiplier} for multiply, {remainder, quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    mul_next = {mul_sum, acc[31:1]};
    div_ge   = (acc[63:31] >= {1'b0, opnd});
    div_diff = acc[62:31] - opnd;
    div_next = div_ge ? {div_diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
  end

  always_comb begin
    prod = md_neg  ? (64'd0 - acc) : acc;
    quo  = md_neg  ? (32'd0 - acc[31:0]) : acc[31:0];
    rem  = rem_neg ? (32'd0 - acc[63:32]) : acc[63:32];
    case (md_f3)
      3'b000:         md_result = prod[31:0];
      3'b001, 3'b010,
      3'b011:         md_result = prod[63:32];
      3'b100, 3'b101: md_result = div_zero ? 32'hFFFF_FFFF : quo;
      default:        md_result = div_zero ? dividend : rem;
    endcase
    md_done_word            = md_hold;
    md_done_word.alu_result = md_result;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      dividend <= '0;
      md_f3    <= '0;
      md_neg   <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
      md_hold  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (id_ex.muldiv) begin
            state    <= S_BUSY;
            cnt      <= '0;
            acc      <= {32'd0, a_mag};
            opnd     <= b_mag;
            dividend <= fwd_a;
            md_f3    <= id_ex.funct3;
            md_neg   <= a_neg ^ b_neg;
            rem_neg  <= a_neg;
            div_zero <= (fwd_b == 32'd0);
            md_hold  <= ex_word;
          end
        end
        S_BUSY: begin
          acc <= md_f3[2] ? div_next : mul_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(MULDIV_ITERS - 1))
            state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ex_busy = reset_n && (((state == S_IDLE) && id_ex.muldiv) || (state == S_BUSY));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ex_mem <= '0;
    else if (state == S_DONE)
      ex_mem <= md_done_word;
    else if (ex_busy)
      ex_mem <= '0;
    else
      ex_mem <= ex_word;
  end
`else
  assign ex_busy = 1'b0;

  // Without the multiply/divide unit an M-extension op degrades to a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ex_mem <= '0;
    else if (id_ex.muldiv)
      ex_mem <= '0;
    else
      ex_mem <= ex_word;
  end
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, random ALU/branch ops
// against a reference model, and multi-cycle multiply/divide and reset sequences.

module tb_execute_stage;
  import decode_pkg::*;
  import execute_pkg::*;

  logic        clk;
  logic        reset_n;
  id_ex_t      id_ex;
  logic [4:0]  exmem_fwd_rd;
  logic        exmem_fwd_we;
  logic [31:0] exmem_fwd_data;
  logic [4:0]  wb_addr;
  logic        wb_we;
  logic [31:0] wb_data;
  ex_mem_t     ex_mem;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ex_busy;

  execute_stage #(.MULDIV_ITERS(32)) dut (
    .clk(clk), .reset_n(reset_n), .id_ex(id_ex),
    .exmem_fwd_rd(exmem_fwd_rd), .exmem_fwd_we(exmem_fwd_we), .exmem_fwd_data(exmem_fwd_data),
    .wb_addr(wb_addr), .wb_we(wb_we), .wb_data(wb_data),
    .ex_mem(ex_mem), .branch_taken(branch_taken), .branch_target(branch_target),
    .ex_busy(ex_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic id_ex_t mk(input logic [1:0] aluop, input logic [2:0] f3, input logic f75,
                                input logic alusrc, input logic br, input logic jmp,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] imm, input logic [31:0] pc4);
    id_ex_t r;
    r = '0;
    r.ALUOp = aluop; r.funct3 = f3; r.funct7_5 = f75; r.ALUSrc = alusrc;
    r.Branch = br; r.Jump = jmp; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
    r.rs1_data = d1; r.rs2_data = d2; r.imm = imm; r.pc_plus4 = pc4;
    r.RegWrite = !br;
    return r;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] rf,
                                          input logic [4:0] xr, input logic xwe, input logic [31:0] xd,
                                          input logic [4:0] wr, input logic wwe, input logic [31:0] wd);
    if (rs == 0) return rf;
    if (xwe && xr == rs) return xd;
    if (wwe && wr == rs) return wd;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input id_ex_t op, input logic [31:0] a, input logic [31:0] rb);
    logic [31:0] b;
    int sa, sb;
    b = op.ALUSrc ? op.imm : rb;
    sa = a; sb = b;
    if (op.ALUOp == 2'b00) return a + b;
    if (op.ALUOp == 2'b01) return a - b;
    if (op.ALUOp == 2'b11) return op.imm;
    case (op.funct3)
      3'd0: return op.funct7_5 ? a - b : a + b;
      3'd1: return a << (b % 32);
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return op.funct7_5 ? 32'(sa >>> (b % 32)) : a >> (b % 32);
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic ref_br(input id_ex_t op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic c;
    sa = a; sb = b;
    case (op.funct3)
      3'd0: c = (a == b);
      3'd1: c = (a != b);
      3'd4: c = (sa < sb);
      3'd5: c = (sa >= sb);
      3'd6: c = (a < b);
      3'd7: c = (a >= b);
      default: c = 1'b0;
    endcase
    return (op.Branch && c) || op.Jump;
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int ia, ib;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
    ia = a; ib = b;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    id_ex_t      op;
    logic [4:0]  xr;
    logic        xwe;
    logic [31:0] xd;
    logic [4:0]  wr;
    logic        wwe;
    logic [31:0] wd;
    logic [31:0] e_alu;
    logic [31:0] e_rs2;
    logic        e_taken;
  } vec_t;

  vec_t vt[$];

  task automatic addv(input string name, input id_ex_t op,
                      input logic [4:0] xr, input logic xwe, input logic [31:0] xd,
                      input logic [4:0] wr, input logic wwe, input logic [31:0] wd,
                      input logic [31:0] e_alu, input logic [31:0] e_rs2, input logic e_taken);
    vec_t v;
    v.name = name; v.op = op; v.xr = xr; v.xwe = xwe; v.xd = xd;
    v.wr = wr; v.wwe = wwe; v.wd = wd;
    v.e_alu = e_alu; v.e_rs2 = e_rs2; v.e_taken = e_taken;
    vt.push_back(v);
  endtask

  // Drives one op right after a clock edge, checks branch outputs, then the registered word.
  task automatic apply(input vec_t v);
    logic [31:0] e_tgt;
    id_ex = v.op;
    exmem_fwd_rd = v.xr; exmem_fwd_we = v.xwe; exmem_fwd_data = v.xd;
    wb_addr = v.wr; wb_we = v.wwe; wb_data = v.wd;
    e_tgt = v.op.pc_plus4 - 32'd4 + v.op.imm;
    #1;
    chk({v.name, " taken"}, 32'(branch_taken), 32'(v.e_taken));
    chk({v.name, " target"}, branch_target, e_tgt);
    @(posedge clk); #1;
    chk({v.name, " alu_result"}, ex_mem.alu_result, v.e_alu);
    chk({v.name, " rs2_data"}, ex_mem.rs2_data, v.e_rs2);
    chk({v.name, " rd/RegWrite"}, {26'd0, ex_mem.RegWrite, ex_mem.rd}, {26'd0, v.op.RegWrite, v.op.rd});
  endtask

  task automatic fwd_off();
    exmem_fwd_rd = 0; exmem_fwd_we = 0; exmem_fwd_data = 0;
    wb_addr = 0; wb_we = 0; wb_data = 0;
  endtask

  // Multi-cycle multiply/divide op with the pipeline holding id_ex while ex_busy is high.
  task automatic run_md(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int busy, bad;
    fwd_off();
    id_ex = mk(2'b10, f3, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd9, a, b, 32'd0, 32'h40);
    id_ex.muldiv = 1'b1;
    #1;
`ifdef MULDIV_EN
    busy = 0; bad = 0;
    while (ex_busy && busy < 100) begin
      busy++;
      if (busy > 1 && (ex_mem.RegWrite || branch_taken)) bad++;
      @(posedge clk); #1;
    end
    chk({name, " busy cycles"}, 32'(busy), 32'd33);
    chk({name, " bubbles"}, 32'(bad), 32'd0);
    chk({name, " done-cycle bubble"}, 32'(ex_mem.RegWrite), 32'd0);
    @(posedge clk); #1;
    chk({name, " result"}, ex_mem.alu_result, ref_md(f3, a, b));
    chk({name, " rd/RegWrite"}, {26'd0, ex_mem.RegWrite, ex_mem.rd}, {26'd0, 1'b1, 5'd9});
`else
    chk({name, " busy"}, 32'(ex_busy), 32'd0);
    @(posedge clk); #1;
    chk({name, " bubble"}, 32'(ex_mem == '0), 32'd1);
`endif
    id_ex = '0;
  endtask

  initial begin
    static logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    vec_t rv;
    logic [31:0] a, b;
    int bad;

    reset_n = 1'b0;
    id_ex = '0;
    fwd_off();
    #1;
    chk("reset ex_mem", 32'(ex_mem == '0), 32'd1);
    chk("reset ex_busy", 32'(ex_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    addv("fwd exmem priority", mk(2'b10, 3'd0, 0, 0, 0, 0, 5'd5, 5'd0, 5'd6, 32'h99, 0, 0, 32'h4),
         5'd5, 1, 32'h10, 5'd5, 1, 32'h20, 32'h10, 32'h0, 0);
    addv("x0 guard", mk(2'b10, 3'd0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd6, 32'h0, 0, 0, 32'h4),
         5'd0, 1, 32'hDEAD, 5'd0, 1, 32'hBEEF, 32'h0, 32'h0, 0);
    addv("fwd memwb", mk(2'b10, 3'd0, 0, 0, 0, 0, 5'd7, 5'd8, 5'd3, 32'h1, 32'h2, 0, 32'h8),
         5'd8, 1, 32'h111, 5'd7, 1, 32'h222, 32'h333, 32'h111, 0);
    addv("fwd we=0", mk(2'b10, 3'd0, 0, 0, 0, 0, 5'd3, 5'd0, 5'd4, 32'h40, 0, 0, 32'h8),
         5'd3, 0, 32'h5, 5'd3, 0, 32'h6, 32'h40, 32'h0, 0);
    addv("BLT", mk(2'b01, 3'd4, 0, 0, 1, 0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h20, 32'h104),
         0, 0, 0, 0, 0, 0, 32'hFFFF_FFFE, 32'h1, 1);
    addv("BLTU", mk(2'b01, 3'd6, 0, 0, 1, 0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h20, 32'h104),
         0, 0, 0, 0, 0, 0, 32'hFFFF_FFFE, 32'h1, 0);
    addv("BEQ back", mk(2'b01, 3'd0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd0, 32'h55, 32'h55, 32'hFFFF_FFF0, 32'h200),
         0, 0, 0, 0, 0, 0, 32'h0, 32'h55, 1);
    addv("BGE min", mk(2'b01, 3'd5, 0, 0, 1, 0, 5'd1, 5'd2, 5'd0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8, 32'h10),
         0, 0, 0, 0, 0, 0, 32'h1, 32'h7FFF_FFFF, 0);
    addv("SUB", mk(2'b10, 3'd0, 1, 0, 0, 0, 5'd1, 5'd2, 5'd5, 32'h5, 32'h7, 0, 32'h4),
         0, 0, 0, 0, 0, 0, 32'hFFFF_FFFE, 32'h7, 0);
    addv("SRA", mk(2'b10, 3'd5, 1, 0, 0, 0, 5'd1, 5'd2, 5'd5, 32'h8000_0010, 32'h4, 0, 32'h4),
         0, 0, 0, 0, 0, 0, 32'hF800_0001, 32'h4, 0);
    addv("SRL", mk(2'b10, 3'd5, 0, 0, 0, 0, 5'd1, 5'd2, 5'd5, 32'h8000_0010, 32'h4, 0, 32'h4),
         0, 0, 0, 0, 0, 0, 32'h0800_0001, 32'h4, 0);
    addv("SLT", mk(2'b10, 3'd2, 0, 0, 0, 0, 5'd1, 5'd2, 5'd5, 32'hFFFF_FFFF, 32'h1, 0, 32'h4),
         0, 0, 0, 0, 0, 0, 32'h1, 32'h1, 0);
    addv("SLTU", mk(2'b10, 3'd3, 0, 0, 0, 0, 5'd1, 5'd2, 5'd5, 32'hFFFF_FFFF, 32'h1, 0, 32'h4),
         0, 0, 0, 0, 0, 0, 32'h0, 32'h1, 0);
    addv("SLL", mk(2'b10, 3'd1, 0, 0, 0, 0, 5'd1, 5'd2, 5'd5, 32'h1, 32'h23, 0, 32'h4),
         0, 0, 0, 0, 0, 0, 32'h8, 32'h23, 0);
    addv("XOR", mk(2'b10, 3'd4, 0, 0, 0, 0, 5'd1, 5'd2, 5'd5, 32'hF0F0, 32'h0FF0, 0, 32'h4),
         0, 0, 0, 0, 0, 0, 32'hFF00, 32'h0FF0, 0);
    addv("OR", mk(2'b10, 3'd6, 0, 0, 0, 0, 5'd1, 5'd2, 5'd5, 32'hF0F0, 32'h0FF0, 0, 32'h4),
         0, 0, 0, 0, 0, 0, 32'hFFF0, 32'h0FF0, 0);
    addv("AND", mk(2'b10, 3'd7, 0, 0, 0, 0, 5'd1, 5'd2, 5'd5, 32'hF0F0, 32'h0FF0, 0, 32'h4),
         0, 0, 0, 0, 0, 0, 32'h00F0, 32'h0FF0, 0);
    addv("LUI", mk(2'b11, 3'd0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd5, 32'h9, 32'h9, 32'h1234_5000, 32'h4),
         0, 0, 0, 0, 0, 0, 32'h1234_5000, 32'h9, 0);
    addv("store fwd rs2", mk(2'b00, 3'd2, 0, 1, 0, 0, 5'd1, 5'd4, 5'd0, 32'h10, 32'hABC, 32'hFFFF_FFFF, 32'h4),
         5'd4, 1, 32'h777, 0, 0, 0, 32'hF, 32'h777, 0);
    addv("JAL", mk(2'b00, 3'd0, 0, 1, 0, 1, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'h100, 32'h804),
         0, 0, 0, 0, 0, 0, 32'h100, 32'h0, 1);

    foreach (vt[i]) apply(vt[i]);

    // Random single-cycle ops checked against the reference model.
    for (int i = 0; i < 60; i++) begin
      rv.name = $sformatf("rand%0d", i);
      rv.op = '0;
      rv.op.ALUOp = 2'($urandom_range(0, 3));
      rv.op.Branch = (rv.op.ALUOp == 2'b01) && ($urandom_range(0, 1) == 1);
      rv.op.funct3 = rv.op.Branch ? br_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      rv.op.funct7_5 = 1'($urandom_range(0, 1));
      rv.op.ALUSrc = !rv.op.Branch && ($urandom_range(0, 2) == 0);
      rv.op.Jump = !rv.op.Branch && ($urandom_range(0, 9) == 0);
      rv.op.rs1 = 5'($urandom_range(0, 7));
      rv.op.rs2 = 5'($urandom_range(0, 7));
      rv.op.rd = 5'($urandom_range(1, 31));
      rv.op.rs1_data = $urandom;
      rv.op.rs2_data = ($urandom_range(0, 3) == 0) ? rv.op.rs1_data : $urandom;
      rv.op.imm = $urandom;
      rv.op.pc_plus4 = {$urandom_range(1, 32'h3FFF_FFFF), 2'b00};
      rv.op.RegWrite = !rv.op.Branch;
      rv.xr = 5'($urandom_range(0, 7)); rv.xwe = 1'($urandom_range(0, 1)); rv.xd = $urandom;
      rv.wr = 5'($urandom_range(0, 7)); rv.wwe = 1'($urandom_range(0, 1)); rv.wd = $urandom;
      a = ref_fwd(rv.op.rs1, rv.op.rs1_data, rv.xr, rv.xwe, rv.xd, rv.wr, rv.wwe, rv.wd);
      b = ref_fwd(rv.op.rs2, rv.op.rs2_data, rv.xr, rv.xwe, rv.xd, rv.wr, rv.wwe, rv.wd);
      rv.e_alu = ref_alu(rv.op, a, b);
      rv.e_rs2 = b;
      rv.e_taken = ref_br(rv.op, a, b);
      apply(rv);
    end

    // Multiply/divide, including back-to-back ops with different operands.
    run_md("MUL",    3'd0, 32'h0001_0000, 32'h0001_0000);
    run_md("MULHU",  3'd3, 32'h0001_0000, 32'h0001_0000);
    run_md("DIV/0",  3'd4, 32'd7, 32'd0);
    run_md("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md("REMU/0", 3'd7, 32'h1234_5678, 32'd0);
    run_md("MULH neg", 3'd1, 32'hFFFF_FFFE, 32'h7FFF_FFFF);
    run_md("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) begin
      a = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      run_md($sformatf("md rand%0d", i), 3'($urandom_range(0, 7)), a, b);
    end

    // Reset pulse in the middle of a multiply aborts it without any write-back.
    fwd_off();
    id_ex = mk(2'b10, 3'd0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd9, 32'h0001_0000, 32'h0001_0000, 0, 32'h40);
    id_ex.muldiv = 1'b1;
    repeat (11) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("abort ex_mem zero", 32'(ex_mem == '0), 32'd1);
    chk("abort ex_busy", 32'(ex_busy), 32'd0);
    @(posedge clk); #1;
    chk("held ex_busy", 32'(ex_busy), 32'd0);
    chk("held ex_mem zero", 32'(ex_mem == '0), 32'd1);
    id_ex = mk(2'b10, 3'd0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd12, 32'd3, 32'd4, 0, 32'h44);
    reset_n = 1'b1;
    #1;
    chk("post-reset busy", 32'(ex_busy), 32'd0);
    @(posedge clk); #1;
    chk("post-reset ADD", ex_mem.alu_result, 32'd7);
    chk("post-reset ADD rd", {26'd0, ex_mem.RegWrite, ex_mem.rd}, {26'd0, 1'b1, 5'd12});
    id_ex = '0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ex_mem.RegWrite && ex_mem.rd == 5'd9) bad++;
      if (ex_busy) bad++;
    end
    chk("aborted op never written", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have parameter MULDIV_ITERS, default 32: iterative multiply/divide step count; legal value 32 only.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port id_ex  input  decode_pkg::id_ex_t  ID/EX register contents. Adds 1-bit field muldiv, set by decode for OP with funct7=0000001.
REQ-005 SHALL have port exmem_fwd_rd / exmem_fwd_we / exmem_fwd_data  input  5/1/32  EX/MEM forward source.
REQ-006 SHALL have port wb_addr / wb_we / wb_data  input  5/1/32  MEM/WB forward source, the same signals that feed decode.
REQ-007 SHALL have port ex_mem  output  execute_pkg::ex_mem_t  fields: alu_result, rs2_data, rd, funct3, pc_plus4, RegWrite, MemRead, MemWrite, MemToReg.
REQ-008 SHALL have port branch_taken  output  1  resolved taken branch/jump.
REQ-009 SHALL have port branch_target  output  32  redirect PC.
REQ-010 SHALL have port ex_busy  output  1  stall request to IF/ID/decode while a muldiv op occupies EX.

Function
REQ-011 SHALL forward operand A from rs1: EX/MEM when exmem_fwd_we && exmem_fwd_rd==id_ex.rs1 && rs1!=0; otherwise MEM/WB on the same match rule; otherwise id_ex.rs1_data. Operand B from rs2 SHALL use the identical rule.
REQ-012 SHALL select ALU B = id_ex.imm when ALUSrc, else forwarded rs2; ex_mem.rs2_data SHALL always be forwarded rs2.
REQ-013 SHALL decode ALUOp: 00 add, 01 subtract/compare, 10 funct3/funct7_5 decode (ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND, 32-bit wrap), 11 pass imm (LUI).
REQ-014 SHALL decode branches (Branch=1) on funct3 BEQ/BNE/BLT/BGE/BLTU/BGEU; branch_target = (pc_plus4 - 4) + imm, modulo 2^32.
REQ-015 SHALL drive branch_taken combinationally, and SHALL force it to 0 while ex_busy.
REQ-016 SHALL register ex_mem on every clock edge with a 1-cycle latency for non-muldiv ops.
REQ-017 SHALL implement the muldiv FSM IDLE->BUSY->DONE->IDLE:
- IDLE with id_ex.muldiv=1: latch operands, counter=0, go to BUSY.
- BUSY: one step per cycle; after MULDIV_ITERS steps go to DONE.
- DONE: always returns to IDLE.
REQ-018 SHALL assert ex_busy in the IDLE start cycle and in every BUSY cycle, and SHALL deassert it in DONE; occupancy is 34 cycles total.
REQ-019 SHALL write a bubble (all control bits 0) into ex_mem during start and BUSY cycles, and the muldiv result with the op's controls at the DONE edge.
REQ-020 SHALL implement muldiv funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-021 SHALL handle division edge cases: divide-by-zero gives quotient 0xFFFFFFFF and remainder = dividend; 0x80000000 / -1 gives quotient 0x80000000 and remainder 0.
REQ-022 SHALL keep a muldiv op in DONE followed by another muldiv op in id_ex as two separate operations, with no reuse of latched operands.

Reset
REQ-023 SHALL, while reset_n=0, drive ex_mem to all zeros, hold the FSM in IDLE with counter 0, and hold ex_busy at 0.
REQ-024 SHALL, on reset assertion mid-operation, abort the muldiv op with no result written; the first cycle after release behaves as IDLE.

Configuration
REQ-025 SHALL, when MULDIV_EN is defined, include the FSM, datapath and ex_busy behaviour of REQ-017 to REQ-022.
REQ-026 SHALL, when MULDIV_EN is undefined, contain no FSM, tie ex_busy to 0, and turn an op with id_ex.muldiv=1 into a bubble in ex_mem.

Verification
REQ-027 Forwarding: x5 written by the EX/MEM op (0x10) and by the MEM/WB op (0x20), ADD x6,x5,x0 -> ex_mem.alu_result=0x10.
REQ-028 x0 guard: exmem_fwd_rd=0, exmem_fwd_we=1, data=0xDEAD, rs1=x0 -> operand A = id_ex.rs1_data = 0.
REQ-029 Branch: BLT, rs1=0xFFFFFFFF, rs2=1, pc_plus4=0x104, imm=0x20 -> branch_taken=1, target=0x120; BLTU with the same operands -> branch_taken=0.
REQ-030 MUL 0x00010000 * 0x00010000 -> ex_busy high 33 cycles, then ex_mem.alu_result=0 with RegWrite=1; MULHU of the same operands -> 0x00000001.
REQ-031 DIV 7 / 0 -> 0xFFFFFFFF; REM 0x80000000 % -1 -> 0; DIV 0x80000000 / -1 -> 0x80000000.
REQ-032 reset_n pulsed low at BUSY cycle 10 -> ex_mem zero, ex_busy=0, no result ever written; a following ADD completes in 1 cycle.
